// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: active-low cathode patterns, scan FSM states
// and the hex-to-segment lookup used by every display block.
package ssd_pkg;

    localparam int N_DIG_DEFAULT = 8;

    // Cathode patterns ordered {a,b,c,d,e,f,g}, 0 = segment lit
    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b1100000;
    localparam logic [6:0] SEG_C   = 7'b0110001;
    localparam logic [6:0] SEG_D   = 7'b1000010;
    localparam logic [6:0] SEG_E   = 7'b0110000;
    localparam logic [6:0] SEG_F   = 7'b0111000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    function automatic logic [6:0] hex2seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational hex nibble to active-low seven-segment cathode decoder.
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex2seg(hex);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed scan controller for an N_DIG seven-segment display with blanking
// guard between digits and frame-aligned commit of new contents.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int N_DIG       = N_DIG_DEFAULT,
    parameter int REFRESH_DIV = 17,
    parameter int BLANK_CYC   = 256
) (
    input  logic               clk,
    input  logic               Reset_n,
    input  logic               upd_req,
    input  logic [4*N_DIG-1:0] upd_data,
    input  logic [N_DIG-1:0]   upd_dp,
    output logic               upd_ack,
    input  logic [N_DIG-1:0]   dig_en,
    output logic [N_DIG-1:0]   An,
    output logic [6:0]         Cath,
    output logic               Dp,
    output logic               frame_tick
);

    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [REFRESH_DIV-1:0] CNT_MAX   = {REFRESH_DIV{1'b1}};
    localparam logic [REFRESH_DIV-1:0] CNT_ONE   = {{(REFRESH_DIV-1){1'b0}}, 1'b1};
    localparam logic [REFRESH_DIV-1:0] BLANK_LIM = REFRESH_DIV'(BLANK_CYC);
    localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(N_DIG - 1);
    localparam logic [IDX_W-1:0]       IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};

    logic [REFRESH_DIV-1:0] cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0]       idx_r, idx_nxt_s;
    scan_state_e            state_r, state_nxt_s;
    logic                   wrap_s, frame_end_s, capture_s, commit_s;

    logic [4*N_DIG-1:0]     stage_data_r, active_data_r;
    logic [N_DIG-1:0]       stage_dp_r, active_dp_r;
    logic                   pending_r;

    logic [3:0]             nibble_s;
    logic [6:0]             seg_s;
    logic [N_DIG-1:0]       an_nxt_s, an_r;
    logic [6:0]             cath_nxt_s, cath_r;
    logic                   dp_nxt_s, dp_r, ack_r, tick_r;

    assign nibble_s = active_data_r[{idx_r, 2'b00} +: 4];

    ssd_hex_decode u_hex_decode (
        .hex (nibble_s),
        .seg (seg_s)
    );

    // Next-state sequencing and next pin values from the current slot position
    always_comb begin
        cnt_nxt_s   = cnt_r + CNT_ONE;
        wrap_s      = (cnt_r == CNT_MAX);
        frame_end_s = wrap_s && (idx_r == IDX_LAST);
        idx_nxt_s   = idx_r;
        an_nxt_s    = {N_DIG{1'b1}};
        cath_nxt_s  = SEG_OFF;
        dp_nxt_s    = 1'b1;
        if (wrap_s) begin
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = {IDX_W{1'b0}};
            end else begin
                idx_nxt_s = idx_r + IDX_ONE;
            end
        end else begin
            idx_nxt_s = idx_r;
        end
        if (cnt_nxt_s < BLANK_LIM) begin
            state_nxt_s = ST_BLANK;
        end else begin
            state_nxt_s = ST_SHOW;
        end
        case (state_r)
            ST_BLANK: begin
                an_nxt_s   = {N_DIG{1'b1}};
                cath_nxt_s = SEG_OFF;
                dp_nxt_s   = 1'b1;
            end
            ST_SHOW: begin
                // Disabled digits keep their slot so on-time per digit stays constant
                an_nxt_s[idx_r] = ~dig_en[idx_r];
                cath_nxt_s      = seg_s;
                dp_nxt_s        = ~active_dp_r[idx_r];
            end
            default: begin
                an_nxt_s   = {N_DIG{1'b1}};
                cath_nxt_s = SEG_OFF;
                dp_nxt_s   = 1'b1;
            end
        endcase
    end

    // Slot counter, digit index and scan state
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_r   <= {REFRESH_DIV{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            state_r <= ST_BLANK;
        end else begin
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            state_r <= state_nxt_s;
        end
    end

    // A request arriving on the ack cycle is dropped: that req belongs to the update just committed
    assign capture_s = upd_req && !pending_r && !ack_r;
    assign commit_s  = frame_end_s && pending_r;

    // Staging capture and frame-aligned commit into the displayed contents
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stage_data_r  <= {(4*N_DIG){1'b0}};
            stage_dp_r    <= {N_DIG{1'b0}};
            active_data_r <= {(4*N_DIG){1'b0}};
            active_dp_r   <= {N_DIG{1'b0}};
            pending_r     <= 1'b0;
        end else if (commit_s) begin
            active_data_r <= stage_data_r;
            active_dp_r   <= stage_dp_r;
            pending_r     <= 1'b0;
        end else if (capture_s) begin
            stage_data_r  <= upd_data;
            stage_dp_r    <= upd_dp;
            pending_r     <= 1'b1;
        end
    end

    // Registered board pins and status pulses
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            an_r   <= {N_DIG{1'b1}};
            cath_r <= SEG_OFF;
            dp_r   <= 1'b1;
            ack_r  <= 1'b0;
            tick_r <= 1'b0;
        end else begin
            an_r   <= an_nxt_s;
            cath_r <= cath_nxt_s;
            dp_r   <= dp_nxt_s;
            ack_r  <= commit_s;
            tick_r <= frame_end_s;
        end
    end

    assign An         = an_r;
    assign Cath       = cath_r;
    assign Dp         = dp_r;
    assign upd_ack    = ack_r;
    assign frame_tick = tick_r;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl with a 16-cycle slot and 2-cycle blanking guard.
module tb_ssd_scan_ctrl;

    logic        clk;
    logic        Reset_n;
    logic        upd_req;
    logic [31:0] upd_data;
    logic [7:0]  upd_dp;
    logic        upd_ack;
    logic [7:0]  dig_en;
    logic [7:0]  An;
    logic [6:0]  Cath;
    logic        Dp;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    logic mon_en = 1'b0;

    ssd_scan_ctrl #(.N_DIG(8), .REFRESH_DIV(4), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .upd_req    (upd_req),
        .upd_data   (upd_data),
        .upd_dp     (upd_dp),
        .upd_ack    (upd_ack),
        .dig_en     (dig_en),
        .An         (An),
        .Cath       (Cath),
        .Dp         (Dp),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;  4'hF: s = 7'b0111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Reference model: cyc = slot-position count since reset (cnt + 16*idx)
    int          cyc;
    int          mc, md;
    logic        bnd;
    logic        m_pend;
    logic [31:0] m_stage_d, m_act_d;
    logic [7:0]  m_stage_dp, m_act_dp;
    logic [7:0]  e_an, nx_an;
    logic [6:0]  e_cath, nx_cath;
    logic        e_dp, nx_dp, e_tick, e_ack;

    always_comb begin
        mc      = cyc % 16;
        md      = (cyc / 16) % 8;
        bnd     = ((cyc % 128) == 127);
        nx_an   = 8'hFF;
        nx_cath = 7'h7F;
        nx_dp   = 1'b1;
        if (mc >= 2) begin
            if (dig_en[md]) nx_an[md] = 1'b0;
            nx_cath = seg_of(m_act_d[md*4 +: 4]);
            nx_dp   = ~m_act_dp[md];
        end
    end

    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cyc <= 0; m_pend <= 1'b0;
            m_stage_d <= 32'h0; m_stage_dp <= 8'h0; m_act_d <= 32'h0; m_act_dp <= 8'h0;
            e_an <= 8'hFF; e_cath <= 7'h7F; e_dp <= 1'b1; e_tick <= 1'b0; e_ack <= 1'b0;
        end else begin
            cyc    <= cyc + 1;
            e_an   <= nx_an;
            e_cath <= nx_cath;
            e_dp   <= nx_dp;
            e_tick <= bnd;
            e_ack  <= bnd && m_pend;
            if (bnd && m_pend) begin
                m_act_d <= m_stage_d; m_act_dp <= m_stage_dp; m_pend <= 1'b0;
            end else if (upd_req && !m_pend && !e_ack) begin
                m_stage_d <= upd_data; m_stage_dp <= upd_dp; m_pend <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk_eq("an", An, e_an);
            chk_eq("cath", Cath, e_cath);
            chk_eq("dp", Dp, e_dp);
            chk_eq("frame_tick", frame_tick, e_tick);
            chk_eq("upd_ack", upd_ack, e_ack);
            chk_eq("an_onehot", ($countones(~An) <= 1), 1);
        end
    end

    // Measures one full frame between consecutive ticks
    task automatic frame_stats(output int period, output int low0, output int low3, output int blank);
        for (int i = 0; i < 300 && frame_tick !== 1'b1; i++) @(negedge clk);
        period = 0; low0 = 0; low3 = 0; blank = 0;
        do begin
            @(negedge clk);
            period++;
            if (An[0] === 1'b0) low0++;
            if (An[3] === 1'b0) low3++;
            if (An === 8'hFF) blank++;
        end while (frame_tick !== 1'b1 && period < 300);
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 300 && upd_ack !== 1'b1; i++) @(negedge clk);
        chk_eq("ack_seen", upd_ack, 1);
        chk_eq("ack_with_tick", frame_tick, 1);
        @(negedge clk);
        upd_req = 1'b0;
    endtask

    task automatic wait_an(input logic [7:0] pat);
        for (int i = 0; i < 300 && An !== pat; i++) @(negedge clk);
        chk_eq("an_reached", An, pat);
    endtask

    int per, l0, l3, bl, acks;

    initial begin
        Reset_n = 1'b1; upd_req = 1'b0; upd_data = 32'h0; upd_dp = 8'h0; dig_en = 8'hFF;
        #1 Reset_n = 1'b0;
        @(negedge clk);
        chk_eq("rst_an", An, 8'hFF);
        chk_eq("rst_cath", Cath, 7'h7F);
        chk_eq("rst_dp", Dp, 1);
        chk_eq("rst_ack", upd_ack, 0);
        chk_eq("rst_tick", frame_tick, 0);
        @(negedge clk);
        Reset_n = 1'b1;
        mon_en  = 1'b1;

        // 1: idle scan of zeros
        wait_an(8'hFB);
        chk_eq("t1_zero", Cath, 7'b0000001);
        frame_stats(per, l0, l3, bl);
        chk_eq("t1_period", per, 128);
        chk_eq("t1_low0", l0, 14);
        chk_eq("t1_low3", l3, 14);
        chk_eq("t1_blank", bl, 16);

        // 2: update committed at frame boundary
        upd_req = 1'b1; upd_data = 32'h7654_3210; upd_dp = 8'h01;
        wait_ack();
        wait_an(8'hFE);
        chk_eq("t2_d0_cath", Cath, 7'b0000001);
        chk_eq("t2_d0_dp", Dp, 0);
        wait_an(8'h7F);
        chk_eq("t2_d7_cath", Cath, 7'b0001111);
        chk_eq("t2_d7_dp", Dp, 1);

        // 3: request while pending is ignored
        repeat (5) @(negedge clk);
        upd_req = 1'b1; upd_data = 32'h1357_9BD0; upd_dp = 8'h00;
        repeat (3) @(negedge clk);
        upd_data = 32'hFFFF_FFFF; upd_dp = 8'hFF;
        wait_ack();
        wait_an(8'hFD);
        chk_eq("t3_first_kept", Cath, 7'b1000010);
        chk_eq("t3_first_dp", Dp, 1);
        upd_req = 1'b1; upd_data = 32'hFFFF_FFFF; upd_dp = 8'h00;
        wait_ack();
        wait_an(8'hFD);
        chk_eq("t3_second", Cath, 7'b0111000);

        // 4: digit enable mask
        dig_en = 8'b1010_1010;
        frame_stats(per, l0, l3, bl);
        chk_eq("t4_period", per, 128);
        chk_eq("t4_low0", l0, 0);
        chk_eq("t4_low3", l3, 14);
        chk_eq("t4_blank", bl, 72);
        dig_en = 8'hFF;

        // 5: reset mid-SHOW with pending update
        for (int i = 0; i < 300 && frame_tick !== 1'b1; i++) @(negedge clk);
        upd_req = 1'b1; upd_data = 32'hABCD_EF01; upd_dp = 8'hFF;
        repeat (3) @(negedge clk);
        upd_req = 1'b0;
        wait_an(8'hFE);
        #2 Reset_n = 1'b0;
        #1;
        chk_eq("t5_an", An, 8'hFF);
        chk_eq("t5_cath", Cath, 7'h7F);
        chk_eq("t5_dp", Dp, 1);
        @(negedge clk);
        @(negedge clk);
        Reset_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (upd_ack === 1'b1) acks++;
        end
        chk_eq("t5_no_ack", acks, 0);
        wait_an(8'hFB);
        chk_eq("t5_zero", Cath, 7'b0000001);

        // 6: wrap and one-hot anodes under changing masks, checked by the model
        for (int f = 0; f < 24; f++) begin
            dig_en = 8'($urandom);
            repeat (16) @(negedge clk);
        end

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
